// File: rtl/sdram_ctrl_param.sv
// rtl/sdram_ctrl_param.sv - parametrised single-word SDR SDRAM controller
// Closed-page accesses with auto-precharge, power-up init sequence and periodic auto-refresh.

module sdram_ctrl_param #(
  parameter int ROW_W   = 13,
  parameter int BA_W    = 2,
  parameter int COL_W   = 10,
  parameter int DQ_W    = 16,
  parameter int CAS_LAT = 2,
  parameter int T_INIT  = 10000,
  parameter int T_RP    = 2,
  parameter int T_RCD   = 2,
  parameter int T_RFC   = 7,
  parameter int T_WR    = 2,
  parameter int T_MRD   = 2,
  parameter int REF_INT = 780
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BA_W+ROW_W+COL_W-1:0]   avs_address,
  input  logic                          avs_read,
  input  logic                          avs_write,
  input  logic [DQ_W-1:0]               avs_writedata,
  input  logic [DQ_W/8-1:0]             avs_byteenable,
  output logic                          avs_ready,
  output logic [DQ_W-1:0]               avs_readdata,
  output logic                          avs_readdatavalid,
  output logic                          init_done,
  output logic [ROW_W-1:0]              sdram_addr,
  output logic [BA_W-1:0]               sdram_ba,
  output logic                          sdram_cs_n,
  output logic                          sdram_ras_n,
  output logic                          sdram_cas_n,
  output logic                          sdram_we_n,
  output logic                          sdram_cke,
  output logic [DQ_W/8-1:0]             sdram_dqm,
  output logic [DQ_W-1:0]               sdram_dq_out,
  input  logic [DQ_W-1:0]               sdram_dq_in,
  output logic                          sdram_dq_oe
);

  localparam int BE_W   = DQ_W / 8;
  localparam int M1     = (T_INIT > T_RFC) ? T_INIT : T_RFC;
  localparam int M2     = (M1 > T_WR + T_RP) ? M1 : T_WR + T_RP;
  localparam int M3     = (M2 > T_MRD) ? M2 : T_MRD;
  localparam int M4     = (M3 > T_RCD) ? M3 : T_RCD;
  localparam int GAP_MX = (M4 > CAS_LAT) ? M4 : CAS_LAT;
  localparam int CNT_W  = $clog2(GAP_MX + 1);
  localparam int RCNT_W = $clog2(REF_INT + 1);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam logic [ROW_W-1:0] A10_BIT  = ROW_W'(1) << 10;
  // Burst length 1, sequential, write burst = programmed burst (A9=0).
  localparam logic [ROW_W-1:0] MRS_ADDR = ROW_W'(CAS_LAT) << 4;

  typedef enum logic [3:0] {
    INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS,
    IDLE, REFRESH, ACTIVATE, RW, RD_WAIT, RECOVER
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_cmd;
  logic [ROW_W-1:0]  r_addr;
  logic [BA_W-1:0]   r_ba;
  logic [BE_W-1:0]   r_dqm;
  logic [DQ_W-1:0]   r_dq_out;
  logic              r_dq_oe;
  logic              r_ready;
  logic [DQ_W-1:0]   r_rdata;
  logic              r_rdv;
  logic              r_init_done;
  logic              r_is_wr;
  logic [COL_W-1:0]  r_col;
  logic [DQ_W-1:0]   r_wdata;
  logic [BE_W-1:0]   r_be;
  logic [RCNT_W-1:0] r_ref_cnt;
  logic              r_ref_pend;

  logic [BA_W-1:0]   w_bank;
  logic [ROW_W-1:0]  w_row;
  logic [ROW_W-1:0]  w_col_addr;
  logic              w_ref_expire;
  logic              w_ref_issue;
  logic              w_ref_pend_nxt;

  assign w_bank         = avs_address[COL_W+ROW_W +: BA_W];
  assign w_row          = avs_address[COL_W +: ROW_W];
  assign w_col_addr     = ROW_W'(r_col) | A10_BIT;
  assign w_ref_expire   = r_init_done && (r_ref_cnt == '0);
  assign w_ref_issue    = (r_state == IDLE) && r_ref_pend;
  // Expiry wins over the clear so a refresh due on the issue edge is not lost.
  assign w_ref_pend_nxt = w_ref_expire | (r_ref_pend & ~w_ref_issue);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ref_cnt  <= '0;
      r_ref_pend <= 1'b0;
    end else if (!r_init_done) begin
      r_ref_cnt  <= RCNT_W'(REF_INT - 1);
      r_ref_pend <= 1'b0;
    end else begin
      r_ref_pend <= w_ref_pend_nxt;
      r_ref_cnt  <= w_ref_expire ? RCNT_W'(REF_INT - 1) : r_ref_cnt - RCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= INIT_WAIT;
      r_cnt       <= CNT_W'(T_INIT - 1);
      r_cmd       <= CMD_NOP;
      r_addr      <= '0;
      r_ba        <= '0;
      r_dqm       <= '1;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_ready     <= 1'b0;
      r_rdata     <= '0;
      r_rdv       <= 1'b0;
      r_init_done <= 1'b0;
      r_is_wr     <= 1'b0;
      r_col       <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
    end else begin
      r_cmd   <= CMD_NOP;
      r_dq_oe <= 1'b0;
      r_rdv   <= 1'b0;
      r_ready <= 1'b0;
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      case (r_state)
        INIT_WAIT: if (r_cnt == '0) begin
          r_cmd   <= CMD_PRE;
          r_addr  <= A10_BIT;
          r_cnt   <= CNT_W'(T_RP);
          r_state <= INIT_PRE;
        end
        INIT_PRE: if (r_cnt == '0) begin
          r_cmd   <= CMD_REF;
          r_cnt   <= CNT_W'(T_RFC);
          r_state <= INIT_REF1;
        end
        INIT_REF1: if (r_cnt == '0) begin
          r_cmd   <= CMD_REF;
          r_cnt   <= CNT_W'(T_RFC);
          r_state <= INIT_REF2;
        end
        INIT_REF2: if (r_cnt == '0) begin
          r_cmd   <= CMD_MRS;
          r_ba    <= '0;
          r_addr  <= MRS_ADDR;
          r_cnt   <= CNT_W'(T_MRD);
          r_state <= INIT_MRS;
        end
        INIT_MRS: if (r_cnt == '0) begin
          r_init_done <= 1'b1;
          r_ready     <= ~w_ref_pend_nxt;
          r_state     <= IDLE;
        end
        IDLE: begin
          if (r_ref_pend) begin
            r_cmd   <= CMD_REF;
            r_cnt   <= CNT_W'(T_RFC);
            r_state <= REFRESH;
          end else if (r_ready && (avs_write || avs_read)) begin
            r_is_wr <= avs_write;
            r_col   <= avs_address[COL_W-1:0];
            r_wdata <= avs_writedata;
            r_be    <= avs_byteenable;
            r_cmd   <= CMD_ACT;
            r_addr  <= w_row;
            r_ba    <= w_bank;
            r_cnt   <= CNT_W'(T_RCD - 1);
            r_state <= ACTIVATE;
          end else begin
            r_ready <= ~w_ref_pend_nxt;
          end
        end
        REFRESH: if (r_cnt == '0) begin
          r_ready <= ~w_ref_pend_nxt;
          r_state <= IDLE;
        end
        ACTIVATE: if (r_cnt == '0) begin
          r_addr <= w_col_addr;
          if (r_is_wr) begin
            r_cmd    <= CMD_WR;
            r_dq_oe  <= 1'b1;
            r_dq_out <= r_wdata;
            r_dqm    <= ~r_be;
            r_cnt    <= CNT_W'(T_WR + T_RP);
            r_state  <= RW;
          end else begin
            r_cmd   <= CMD_RD;
            r_dqm   <= '0;
            r_cnt   <= CNT_W'(CAS_LAT);
            r_state <= RD_WAIT;
          end
        end
        RW: begin
          r_dqm <= '1;
          if (r_cnt == '0) begin
            r_ready <= ~w_ref_pend_nxt;
            r_state <= IDLE;
          end
        end
        // DQM stays low until capture so the read word is never masked at CAS 3.
        RD_WAIT: if (r_cnt == '0) begin
          r_rdata <= sdram_dq_in;
          r_rdv   <= 1'b1;
          r_dqm   <= '1;
          r_cnt   <= CNT_W'(T_RP);
          r_state <= RECOVER;
        end
        RECOVER: if (r_cnt == '0) begin
          r_ready <= ~w_ref_pend_nxt;
          r_state <= IDLE;
        end
        default: r_state <= INIT_WAIT;
      endcase
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = r_cmd;
  assign sdram_cke         = 1'b1;
  assign sdram_addr        = r_addr;
  assign sdram_ba          = r_ba;
  assign sdram_dqm         = r_dqm;
  assign sdram_dq_out      = r_dq_out;
  assign sdram_dq_oe       = r_dq_oe;
  assign avs_ready         = r_ready;
  assign avs_readdata      = r_rdata;
  assign avs_readdatavalid = r_rdv;
  assign init_done         = r_init_done;

endmodule

// File: tb/tb_sdram_ctrl_param.sv
// tb/tb_sdram_ctrl_param.sv - directed bench for sdram_ctrl_param
// Echoing SDRAM model, refresh interval monitor and hand-computed expectations.

module tb_sdram_ctrl_param;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [24:0] avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [15:0] avs_writedata = '0;
  logic [1:0]  avs_byteenable = '0;
  logic        avs_ready;
  logic [15:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        init_done;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_cke;
  logic [1:0]  sdram_dqm;
  logic [15:0] sdram_dq_out;
  logic [15:0] sdram_dq_in = 16'hdead;
  logic        sdram_dq_oe;
  logic [3:0]  cmd;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_ref = -1;
  int ref_hold = 0;
  int ref_total = 0;

  assign cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

  sdram_ctrl_param #(
    .ROW_W(13), .BA_W(2), .COL_W(10), .DQ_W(16), .CAS_LAT(2),
    .T_INIT(8), .T_RP(2), .T_RCD(2), .T_RFC(3), .T_WR(2), .T_MRD(2), .REF_INT(50)
  ) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_ready(avs_ready), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .init_done(init_done),
    .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_cke(sdram_cke), .sdram_dqm(sdram_dqm),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_in(sdram_dq_in),
    .sdram_dq_oe(sdram_dq_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SDRAM model: stores written bytes, returns read data CAS 2 cycles after RD.
  logic [15:0] mem [logic [24:0]];
  logic [12:0] act_row = '0;
  logic [15:0] rd_word = '0;
  int          rd_dly = 0;

  always @(negedge clk) begin
    logic [24:0] key;
    logic [15:0] w;
    sdram_dq_in = 16'hdead;
    if (rd_dly != 0) begin
      rd_dly--;
      if (rd_dly == 0) sdram_dq_in = rd_word;
    end
    key = {sdram_ba, act_row, sdram_addr[9:0]};
    if (cmd == ACT) act_row = sdram_addr;
    if (cmd == WR) begin
      w = mem.exists(key) ? mem[key] : 16'h0000;
      for (int b = 0; b < 2; b++)
        if (!sdram_dqm[b]) w[b*8 +: 8] = sdram_dq_out[b*8 +: 8];
      mem[key] = w;
    end
    if (cmd == RD) begin
      rd_word = mem.exists(key) ? mem[key] : 16'h0000;
      rd_dly  = 2;
    end
  end

  // Refresh monitor: spacing of REF after init and avs_ready held low across tRFC.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      last_ref = -1;
      ref_hold = 0;
    end else begin
      if (ref_hold > 0) begin
        check("ref_busy_ready", avs_ready, 0);
        ref_hold--;
      end
      if (cmd == REF && init_done) begin
        check("ref_ready", avs_ready, 0);
        if (last_ref >= 0)
          check("ref_gap_40_60", (cyc - last_ref >= 40) && (cyc - last_ref <= 60), 1);
        last_ref = cyc;
        ref_total++;
        ref_hold = 3;
      end
    end
  end

  task automatic count_nops(output int n);
    n = 0;
    while (cmd == NOP && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Entered at a negedge with reset already high for at least one edge.
  task automatic init_seq();
    int n;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_cmd", cmd, NOP);
    check("rst_cke", sdram_cke, 1);
    check("rst_addr", sdram_addr, 0);
    check("rst_ba", sdram_ba, 0);
    check("rst_dqm", sdram_dqm, 2'b11);
    check("rst_oe", sdram_dq_oe, 0);
    check("rst_dq_out", sdram_dq_out, 0);
    check("rst_ready", avs_ready, 0);
    check("rst_rdv", avs_readdatavalid, 0);
    check("rst_rdata", avs_readdata, 0);
    check("rst_init_done", init_done, 0);
    count_nops(n);
    check("init_nops", n, 8);
    check("init_pre", cmd, PRE);
    check("init_pre_a10", sdram_addr[10], 1);
    @(negedge clk);
    count_nops(n);
    check("trp_nops", n, 2);
    check("init_ref1", cmd, REF);
    @(negedge clk);
    count_nops(n);
    check("trfc1_nops", n, 3);
    check("init_ref2", cmd, REF);
    @(negedge clk);
    count_nops(n);
    check("trfc2_nops", n, 3);
    check("init_mrs", cmd, MRS);
    check("mrs_addr", sdram_addr, 13'h020);
    check("mrs_ba", sdram_ba, 0);
    repeat (2) begin
      @(negedge clk);
      check("tmrd_nop", cmd, NOP);
      check("tmrd_init_done", init_done, 0);
    end
    @(negedge clk);
    check("init_done", init_done, 1);
    check("idle_ready", avs_ready, 1);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!avs_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("ready_seen", avs_ready, 1);
  endtask

  task automatic access(input logic wr, input logic rd, input logic [24:0] a,
                        input logic [15:0] wd, input logic [1:0] be,
                        input logic [15:0] exp_rd);
    logic [1:0]  nbe;
    logic [12:0] exp_ca;
    nbe    = ~be;
    exp_ca = {3'b001, a[9:0]};
    wait_ready();
    avs_write = wr; avs_read = rd; avs_address = a;
    avs_writedata = wd; avs_byteenable = be;
    @(posedge clk);
    #1 avs_write = 1'b0; avs_read = 1'b0;
    @(negedge clk);
    check("act_cmd", cmd, ACT);
    check("act_row", sdram_addr, a[22:10]);
    check("act_ba", sdram_ba, a[24:23]);
    check("act_ready", avs_ready, 0);
    @(negedge clk);
    check("trcd_nop", cmd, NOP);
    @(negedge clk);
    if (wr) begin
      check("wr_cmd", cmd, WR);
      check("wr_addr", sdram_addr, exp_ca);
      check("wr_oe", sdram_dq_oe, 1);
      check("wr_data", sdram_dq_out, wd);
      check("wr_dqm", sdram_dqm, nbe);
      @(negedge clk);
      check("wrrec_cmd", cmd, NOP);
      check("wrrec_oe", sdram_dq_oe, 0);
      check("wrrec_dqm", sdram_dqm, 2'b11);
    end else begin
      check("rd_cmd", cmd, RD);
      check("rd_addr", sdram_addr, exp_ca);
      check("rd_dqm", sdram_dqm, 2'b00);
      repeat (2) begin
        @(negedge clk);
        check("rdv_early", avs_readdatavalid, 0);
      end
      @(negedge clk);
      check("rdv_pulse", avs_readdatavalid, 1);
      check("rd_data", avs_readdata, exp_rd);
      @(negedge clk);
      check("rdv_single", avs_readdatavalid, 0);
      check("rd_data_hold", avs_readdata, exp_rd);
    end
  endtask

  initial begin
    logic [24:0] addr_a;
    logic [24:0] addr_b;
    int refs0;
    addr_a = {2'd1, 13'h123, 10'h045};
    addr_b = {2'd2, 13'h0aa, 10'h011};

    repeat (2) @(negedge clk);
    init_seq();

    access(1'b1, 1'b0, addr_a, 16'hbeef, 2'b11, 16'h0000);
    access(1'b0, 1'b1, addr_a, 16'h0000, 2'b00, 16'hbeef);
    access(1'b1, 1'b0, addr_a, 16'h1234, 2'b01, 16'h0000);
    access(1'b0, 1'b1, addr_a, 16'h0000, 2'b00, 16'hbe34);

    // Read and write together: the write wins.
    access(1'b1, 1'b1, addr_b, 16'h5a5a, 2'b11, 16'h0000);
    access(1'b0, 1'b1, addr_b, 16'h0000, 2'b00, 16'h5a5a);

    refs0 = ref_total;
    for (int i = 0; i < 24; i++)
      access(1'b0, 1'b1, addr_a, 16'h0000, 2'b00, 16'hbe34);
    check("refs_during_reads", (ref_total - refs0) >= 3, 1);

    // Reset one cycle after RD reaches the pins.
    wait_ready();
    avs_read = 1'b1; avs_address = addr_b;
    @(posedge clk);
    #1 avs_read = 1'b0;
    @(negedge clk);
    check("mid_act", cmd, ACT);
    @(negedge clk);
    @(negedge clk);
    check("mid_rd", cmd, RD);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_cmd", cmd, NOP);
    check("mid_rst_dqm", sdram_dqm, 2'b11);
    check("mid_rst_init_done", init_done, 0);
    check("mid_rst_ready", avs_ready, 0);
    check("mid_rst_rdata", avs_readdata, 0);
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_no_rdv", avs_readdatavalid, 0);
    end
    init_seq();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
